jk_bank_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares one bank of NBITS JK flip-flops between NREQ requesters.

---
 rtl/jk_bank_arbiter.sv | 170 +++++++++++++++++
 tb/tb_jk_bank_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : jk_bank_arbiter
// Brief   : Round-robin arbiter/sequencer sharing one bank of JK flip-flops
//           between NREQ requesters; one drive cycle, one sample cycle.
// Rev     : 1.0
// ============================================================================
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [2*NREQ-1:0]       req_op_i,
  input  logic [IDXW*NREQ-1:0]    req_idx_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic [NBITS-1:0]        j_out_o,
  output logic [NBITS-1:0]        k_out_o,
  input  logic [NBITS-1:0]        q_in_i,
  output logic                    rsp_valid_o,
  output logic [$clog2(NREQ)-1:0] rsp_id_o,
  output logic                    rsp_q_o,
  output logic                    rsp_err_o,
  output logic                    busy_o
);

  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [NBITS-1:0] sel_q, sel_d;
  logic             err_q, err_d;
  logic [NBITS-1:0] j_q, j_d;
  logic [NBITS-1:0] k_q, k_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_q_q, rsp_q_d;
  logic             rsp_err_q, rsp_err_d;

  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_cand;
  logic [1:0]       w_op;
  logic [IDXW-1:0]  w_idx;
  logic [NBITS-1:0] w_mask;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] base, input int step);
    int s;
    s = int'(base) + step;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Round-robin search from the pointer; an empty mask marks an out-of-range index.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    w_op    = '0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = wrap_inc(ptr_q, i);
      if (!w_found && req_valid_i[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
    for (int r = 0; r < NREQ; r++) begin
      if (w_win == IDW'(r)) begin
        w_op  = req_op_i[2*r +: 2];
        w_idx = req_idx_i[IDXW*r +: IDXW];
      end
    end
    for (int b = 0; b < NBITS; b++) begin
      w_mask[b] = (w_idx == IDXW'(b));
    end
  end

  always_comb begin
    req_ready_o = '0;
    for (int r = 0; r < NREQ; r++) begin
      req_ready_o[r] = (state_q == ST_IDLE) && w_found && (w_win == IDW'(r));
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    sel_d       = sel_q;
    err_d       = err_q;
    j_d         = '0;
    k_d         = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_q_d     = rsp_q_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (w_found) begin
          state_d = ST_DRIVE;
          ptr_d   = wrap_inc(w_win, 1);
          id_d    = w_win;
          sel_d   = w_mask;
          err_d   = ~|w_mask;
          j_d     = w_mask & {NBITS{w_op[1]}};
          k_d     = w_mask & {NBITS{w_op[0]}};
        end
      end
      ST_DRIVE: begin
        state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_q_d     = |(q_in_i & sel_q);
        rsp_err_d   = err_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      sel_q       <= '0;
      err_q       <= 1'b0;
      j_q         <= '0;
      k_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_q_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
      j_q         <= j_d;
      k_q         <= k_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_q_q     <= rsp_q_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign j_out_o     = j_q;
  assign k_out_o     = k_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_q_o     = rsp_q_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_jk_bank_arbiter
// Brief   : Self-checking bench for jk_bank_arbiter with a JK bank model.
// Rev     : 1.0
// ============================================================================
module tb_jk_bank_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bank_clr = 1'b1;

  logic [3:0]  rv;
  logic [7:0]  rop;
  logic [11:0] ridx;
  logic [3:0]  ready;
  logic [7:0]  jo, ko, bank;
  logic        rspv, rq, rerr, busy;
  logic [1:0]  rid;

  logic [3:0]  rv6;
  logic [7:0]  rop6;
  logic [11:0] ridx6;
  logic [3:0]  rdy6;
  logic [5:0]  j6, k6, bank6;
  logic        rspv6, rq6, rerr6, busy6;
  logic [1:0]  rid6;

  jk_bank_arbiter #(.NREQ(4), .NBITS(8), .IDXW(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(rv), .req_op_i(rop), .req_idx_i(ridx), .req_ready_o(ready),
    .j_out_o(jo), .k_out_o(ko), .q_in_i(bank),
    .rsp_valid_o(rspv), .rsp_id_o(rid), .rsp_q_o(rq), .rsp_err_o(rerr), .busy_o(busy)
  );

  jk_bank_arbiter #(.NREQ(4), .NBITS(6), .IDXW(3)) dut6 (
    .clk(clk), .reset(reset),
    .req_valid_i(rv6), .req_op_i(rop6), .req_idx_i(ridx6), .req_ready_o(rdy6),
    .j_out_o(j6), .k_out_o(k6), .q_in_i(bank6),
    .rsp_valid_o(rspv6), .rsp_id_o(rid6), .rsp_q_o(rq6), .rsp_err_o(rerr6), .busy_o(busy6)
  );

  always #5 clk = ~clk;

  // Physical JK banks, cleared only by their own clear.
  always @(posedge clk) begin
    if (bank_clr) bank <= '0;
    else for (int b = 0; b < 8; b++)
      case ({jo[b], ko[b]})
        2'b01: bank[b] <= 1'b0;
        2'b10: bank[b] <= 1'b1;
        2'b11: bank[b] <= ~bank[b];
        default: ;
      endcase
  end

  always @(posedge clk) begin
    if (bank_clr) bank6 <= '0;
    else for (int b = 0; b < 6; b++)
      case ({j6[b], k6[b]})
        2'b01: bank6[b] <= 1'b0;
        2'b10: bank6[b] <= 1'b1;
        2'b11: bank6[b] <= ~bank6[b];
        default: ;
      endcase
  end

  int nerr = 0, nchk = 0;

  // Transaction-level reference: absolute cycle of drive/response, free time, pointer.
  int cyc = 0, free_at = 0, drv_cyc = -1, rsp_cyc = -1, m_ptr = 0;
  logic [7:0] p_j, p_k;
  logic [1:0] p_id, e_id;
  bit p_q, p_err, e_q, e_err;
  bit mbank [8];
  logic [3:0] sticky;
  bit rnd;

  int obs_gnt[$];
  int obs_gcyc[$];
  int obs_rid[$];
  int obs_rq[$];
  int obs_rerr[$];
  int obs_j[$];
  int obs_k[$];

  task automatic clear_obs();
    obs_gnt.delete(); obs_gcyc.delete(); obs_rid.delete(); obs_rq.delete();
    obs_rerr.delete(); obs_j.delete(); obs_k.delete();
  endtask

  task automatic cycle();
    int g, idx;
    logic [3:0] er;
    logic [7:0] ej, ek;
    logic [1:0] op;
    bit erv, eb, old, nw;
    @(negedge clk);
    g = -1;
    if (cyc >= free_at)
      for (int i = 0; i < 4; i++)
        if (g < 0 && rv[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
    er  = (g >= 0) ? 4'(1 << g) : 4'b0;
    ej  = (cyc == drv_cyc) ? p_j : 8'h00;
    ek  = (cyc == drv_cyc) ? p_k : 8'h00;
    erv = (cyc == rsp_cyc);
    eb  = (cyc < free_at);
    if (erv) begin e_id = p_id; e_q = p_q; e_err = p_err; end
    nchk += 8;
    if (ready !== er) begin nerr++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready, er); end
    if (busy !== eb) begin nerr++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, eb); end
    if (jo !== ej) begin nerr++; $display("FAIL j_out cyc=%0d got=%h exp=%h", cyc, jo, ej); end
    if (ko !== ek) begin nerr++; $display("FAIL k_out cyc=%0d got=%h exp=%h", cyc, ko, ek); end
    if (rspv !== erv) begin nerr++; $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rspv, erv); end
    if (rid !== e_id) begin nerr++; $display("FAIL rsp_id cyc=%0d got=%0d exp=%0d", cyc, rid, e_id); end
    if (rq !== e_q) begin nerr++; $display("FAIL rsp_q cyc=%0d got=%b exp=%b", cyc, rq, e_q); end
    if (rerr !== e_err) begin nerr++; $display("FAIL rsp_err cyc=%0d got=%b exp=%b", cyc, rerr, e_err); end
    if (!reset)
      for (int r = 0; r < 4; r++)
        if (ready[r] === 1'b1) begin obs_gnt.push_back(r); obs_gcyc.push_back(cyc); end
    if (rspv === 1'b1) begin
      obs_rid.push_back(int'(rid)); obs_rq.push_back(int'(rq)); obs_rerr.push_back(int'(rerr));
    end
    if (jo !== 8'h00) obs_j.push_back(int'(jo));
    if (ko !== 8'h00) obs_k.push_back(int'(ko));
    @(posedge clk); #1;
    if (reset) begin
      m_ptr = 0; free_at = 0; drv_cyc = -1; rsp_cyc = -1;
      e_id = '0; e_q = 1'b0; e_err = 1'b0;
    end else if (g >= 0) begin
      idx   = int'(ridx[3*g +: 3]);
      op    = rop[2*g +: 2];
      p_err = (idx >= 8);
      old   = p_err ? 1'b0 : mbank[idx];
      case (op)
        2'b00:   nw = old;
        2'b01:   nw = 1'b0;
        2'b10:   nw = 1'b1;
        default: nw = ~old;
      endcase
      if (!p_err) mbank[idx] = nw;
      p_q     = p_err ? 1'b0 : nw;
      p_id    = 2'(g);
      p_j     = (!p_err && op[1]) ? 8'(1 << idx) : 8'h00;
      p_k     = (!p_err && op[0]) ? 8'(1 << idx) : 8'h00;
      drv_cyc = cyc + 1;
      rsp_cyc = cyc + 3;
      free_at = cyc + 3;
      m_ptr   = (g + 1) % 4;
      rv[g]   = sticky[g];
    end
    cyc++;
    if (rnd)
      for (int r = 0; r < 4; r++) begin
        if (!rv[r] && $urandom_range(0, 2) == 0) begin
          rv[r] = 1'b1;
          rop[2*r +: 2]  = 2'($urandom_range(0, 3));
          ridx[3*r +: 3] = 3'($urandom_range(0, 7));
        end else if (rv[r] && $urandom_range(0, 15) == 0) begin
          rv[r] = 1'b0;
        end
      end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic drain();
    rv = '0; sticky = '0; rnd = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic test_reset();
    @(negedge clk);
    nchk += 8;
    if (ready !== 4'b0) begin nerr++; $display("FAIL reset_ready got=%b exp=0", ready); end
    if (jo !== 8'h0) begin nerr++; $display("FAIL reset_j got=%h exp=0", jo); end
    if (ko !== 8'h0) begin nerr++; $display("FAIL reset_k got=%h exp=0", ko); end
    if (rspv !== 1'b0) begin nerr++; $display("FAIL reset_rsp_valid got=%b exp=0", rspv); end
    if (rid !== 2'd0) begin nerr++; $display("FAIL reset_rsp_id got=%0d exp=0", rid); end
    if (rq !== 1'b0) begin nerr++; $display("FAIL reset_rsp_q got=%b exp=0", rq); end
    if (rerr !== 1'b0) begin nerr++; $display("FAIL reset_rsp_err got=%b exp=0", rerr); end
    if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_set_bit();
    clear_obs();
    rv = 4'b0100; rop[5:4] = 2'b10; ridx[8:6] = 3'd5;
    repeat (5) cycle();
    nchk += 3;
    if (obs_gnt.size() != 1 || obs_gnt[0] != 2) begin nerr++; $display("FAIL set_grant got_n=%0d exp=1 grant to 2", obs_gnt.size()); end
    if (obs_j.size() != 1 || obs_j[0] != 'h20) begin nerr++; $display("FAIL set_j_pulse got_n=%0d exp one 0x20", obs_j.size()); end
    if (obs_rid.size() != 1 || obs_rid[0] != 2 || obs_rq[0] != 1 || obs_rerr[0] != 0) begin
      nerr++; $display("FAIL set_rsp got_n=%0d exp one rsp id=2 q=1 err=0", obs_rid.size());
    end
    drain();
  endtask

  task automatic test_rr_toggle();
    do_reset();
    clear_obs();
    rv = 4'b1111; sticky = 4'b1111;
    for (int r = 0; r < 4; r++) begin rop[2*r +: 2] = 2'b11; ridx[3*r +: 3] = 3'd1; end
    repeat (14) cycle();
    drain();
    nchk += 3;
    if (obs_gnt.size() < 5 || obs_gnt[0] != 0 || obs_gnt[1] != 1 || obs_gnt[2] != 2 || obs_gnt[3] != 3 || obs_gnt[4] != 0) begin
      nerr++; $display("FAIL rr_order got_n=%0d exp order 0,1,2,3,0", obs_gnt.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nchk++;
        if (obs_gcyc[i+1] - obs_gcyc[i] != 3) begin nerr++; $display("FAIL rr_spacing got=%0d exp=3", obs_gcyc[i+1] - obs_gcyc[i]); end
      end
    end
    if (obs_rq.size() < 4 || obs_rq[0] != 1 || obs_rq[1] != 0 || obs_rq[2] != 1 || obs_rq[3] != 0) begin
      nerr++; $display("FAIL rr_toggle_q got_n=%0d exp q 1,0,1,0", obs_rq.size());
    end
    if (obs_rid.size() < 4 || obs_rid[0] != 0 || obs_rid[3] != 3) begin
      nerr++; $display("FAIL rr_rsp_id got_n=%0d exp ids 0..3", obs_rid.size());
    end
  endtask

  task automatic test_read();
    rv = 4'b0010; rop[3:2] = 2'b10; ridx[5:3] = 3'd7;
    repeat (4) cycle();
    clear_obs();
    rv = 4'b0010; rop[3:2] = 2'b00; ridx[5:3] = 3'd7;
    repeat (4) cycle();
    nchk += 2;
    if (obs_j.size() != 0 || obs_k.size() != 0) begin nerr++; $display("FAIL read_pins got j_n=%0d k_n=%0d exp 0", obs_j.size(), obs_k.size()); end
    if (obs_rq.size() != 1 || obs_rq[0] != 1 || obs_rid[0] != 1) begin nerr++; $display("FAIL read_rsp got_n=%0d exp one rsp id=1 q=1", obs_rq.size()); end
    drain();
  endtask

  task automatic test_err_idx();
    @(posedge clk); #1;
    rv6 = 4'b0001; rop6[1:0] = 2'b10; ridx6[2:0] = 3'd6;
    @(negedge clk); nchk++;
    if (rdy6 !== 4'b0001) begin nerr++; $display("FAIL err_ready got=%b exp=0001", rdy6); end
    @(posedge clk); #1; rv6 = '0;
    @(negedge clk); nchk += 3;
    if (j6 !== 6'h0) begin nerr++; $display("FAIL err_j got=%h exp=0", j6); end
    if (k6 !== 6'h0) begin nerr++; $display("FAIL err_k got=%h exp=0", k6); end
    if (busy6 !== 1'b1) begin nerr++; $display("FAIL err_busy got=%b exp=1", busy6); end
    @(negedge clk); nchk++;
    if (rspv6 !== 1'b0) begin nerr++; $display("FAIL err_early_rsp got=%b exp=0", rspv6); end
    @(negedge clk); nchk += 4;
    if (rspv6 !== 1'b1) begin nerr++; $display("FAIL err_rsp_valid got=%b exp=1", rspv6); end
    if (rerr6 !== 1'b1) begin nerr++; $display("FAIL err_flag got=%b exp=1", rerr6); end
    if (rq6 !== 1'b0) begin nerr++; $display("FAIL err_q got=%b exp=0", rq6); end
    if (rid6 !== 2'd0) begin nerr++; $display("FAIL err_id got=%0d exp=0", rid6); end
    @(posedge clk); #1;
    rv6 = 4'b0010; rop6[3:2] = 2'b10; ridx6[5:3] = 3'd5;
    @(negedge clk); nchk++;
    if (rdy6 !== 4'b0010) begin nerr++; $display("FAIL narrow_ready got=%b exp=0010", rdy6); end
    @(posedge clk); #1; rv6 = '0;
    @(negedge clk); nchk += 2;
    if (j6 !== 6'h20) begin nerr++; $display("FAIL narrow_j got=%h exp=20", j6); end
    if (k6 !== 6'h00) begin nerr++; $display("FAIL narrow_k got=%h exp=0", k6); end
    @(negedge clk);
    @(negedge clk); nchk += 4;
    if (rspv6 !== 1'b1) begin nerr++; $display("FAIL narrow_rsp_valid got=%b exp=1", rspv6); end
    if (rerr6 !== 1'b0) begin nerr++; $display("FAIL narrow_err got=%b exp=0", rerr6); end
    if (rq6 !== 1'b1) begin nerr++; $display("FAIL narrow_q got=%b exp=1", rq6); end
    if (rid6 !== 2'd1) begin nerr++; $display("FAIL narrow_id got=%0d exp=1", rid6); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    clear_obs();
    rv = 4'b0100; sticky = 4'b0100; rop[5:4] = 2'b11; ridx[8:6] = 3'd3;
    cycle();
    reset = 1'b1; rv[0] = 1'b1; rop[1:0] = 2'b01; ridx[2:0] = 3'd2;
    cycle();
    reset = 1'b0;
    repeat (4) cycle();
    nchk += 2;
    if (obs_gnt.size() < 2 || obs_gnt[0] != 2 || obs_gnt[1] != 0) begin nerr++; $display("FAIL midreset_grant got_n=%0d exp 2 then 0", obs_gnt.size()); end
    if (obs_rid.size() != 1 || obs_rid[0] != 0) begin nerr++; $display("FAIL midreset_rsp got_n=%0d exp one rsp id=0", obs_rid.size()); end
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    clear_obs();
    rv = 4'b1000; rop[7:6] = 2'b00; ridx[11:9] = 3'd0;
    cycle();
    rv = 4'b1001; rop[1:0] = 2'b00; ridx[2:0] = 3'd4;
    repeat (8) cycle();
    nchk++;
    if (obs_gnt.size() != 3 || obs_gnt[0] != 3 || obs_gnt[1] != 0 || obs_gnt[2] != 3) begin
      nerr++; $display("FAIL wrap_order got_n=%0d exp order 3,0,3", obs_gnt.size());
    end
    drain();
  endtask

  task automatic test_random();
    rnd = 1'b1;
    repeat (400) cycle();
    drain();
  endtask

  initial begin
    rv = '0; rop = '0; ridx = '0; rv6 = '0; rop6 = '0; ridx6 = '0;
    sticky = '0; rnd = 1'b0;
    e_id = '0; e_q = 1'b0; e_err = 1'b0;
    p_j = '0; p_k = '0; p_id = '0; p_q = 1'b0; p_err = 1'b0;
    for (int b = 0; b < 8; b++) mbank[b] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bank_clr = 1'b0;
    test_reset();
    test_set_bit();
    test_rr_toggle();
    test_read();
    test_err_idx();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
